// File: rtl/event_packetizer_pkg.sv
// Shared types and helpers for the event packetizer and its FIFO.
// The optional drop-on-full mode is selected with the EVENT_DROP_EN macro.
package event_packetizer_pkg;

  localparam int DEF_ROW_ADD = 4;
  localparam int DEF_COL_ADD = 4;
  localparam int DEF_SIZE    = 32;

  localparam logic POLARITY_ON = 1'b1;

  // Packet layout for the default geometry, MSB first.
  typedef struct packed {
    logic [DEF_SIZE-1:0]    ts;
    logic [DEF_ROW_ADD-1:0] row;
    logic [DEF_COL_ADD-1:0] col;
    logic                   pol;
  } event_pkt_t;

  function automatic int pkt_width(input int size, input int row_add, input int col_add);
    return size + row_add + col_add + 1;
  endfunction

endpackage

// File: rtl/event_packetizer_sync_fifo.sv
// Synchronous FIFO with a registered level and a registered head word.
// The head register is refilled from the array or bypassed from din when the FIFO drains.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [LW-1:0]    level_reg;
  logic [LW-1:0]    level_next;
  logic [LW-1:0]    held;
  logic [WIDTH-1:0] dout_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full        = (level_reg == LW'(DEPTH));
  assign empty       = (level_reg == '0);
  assign push_ok     = push && !full;
  assign pop_ok      = pop && !empty;
  assign rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
  assign held        = level_reg - LW'(pop_ok);
  assign level_next  = held + LW'(push_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push_ok);
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      // Entries surviving the pop come from the array; otherwise the pushed word becomes the head.
      if (held != '0) begin
        dout_reg <= mem[rd_ptr_next];
      end else if (push_ok) begin
        dout_reg <= din;
      end
    end
  end

  assign dout  = dout_reg;
  assign level = level_reg;

endmodule

// File: rtl/event_packetizer.sv
// Timestamps granted pixel events and queues them for the readout link.
// Define EVENT_DROP_EN to never stall the arbiter and count events lost while full.
module event_packetizer
  import event_packetizer_pkg::*;
#(
  parameter  int ROW_ADD = 4,
  parameter  int COL_ADD = 4,
  parameter  int SIZE    = 32,
  parameter  int DEPTH   = 16,
  parameter  int TS_DIV  = 1,
  localparam int WIDTH   = pkt_width(SIZE, ROW_ADD, COL_ADD),
  localparam int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               ev_valid_i,
  output logic               ev_ready_o,
  input  logic [ROW_ADD-1:0] ev_row_i,
  input  logic [COL_ADD-1:0] ev_col_i,
  input  logic               ev_pol_i,
  output logic               pkt_valid_o,
  input  logic               pkt_ready_i,
  output logic [WIDTH-1:0]   pkt_data_o,
  output logic [LEVEL_W-1:0] fifo_level_o,
  output logic [15:0]        drop_cnt_o
);

  localparam int              PRE_W    = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TS_DIV - 1);

  logic [PRE_W-1:0] pre_reg;
  logic [SIZE-1:0]  ts_reg;
  logic [WIDTH-1:0] din;
  logic             full;
  logic             empty;
  logic             push;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pre_reg <= '0;
      ts_reg  <= '0;
    end else if (enable_i) begin
      if (pre_reg == PRE_LAST) begin
        pre_reg <= '0;
        ts_reg  <= ts_reg + SIZE'(1);
      end else begin
        pre_reg <= pre_reg + PRE_W'(1);
      end
    end
  end

  assign din = {ts_reg, ev_row_i, ev_col_i, ev_pol_i};

`ifdef EVENT_DROP_EN
  logic [15:0] drop_reg;

  assign ev_ready_o = 1'b1;
  assign push       = ev_valid_i && !full;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      drop_reg <= '0;
    end else if (ev_valid_i && full && (drop_reg != 16'hFFFF)) begin
      drop_reg <= drop_reg + 16'd1;
    end
  end

  assign drop_cnt_o = drop_reg;
`else
  // Registered so ready stays low through reset without a path from reset_i.
  logic run_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  assign ev_ready_o = run_reg && !full;
  assign push       = ev_valid_i && ev_ready_o;
  assign drop_cnt_o = '0;
`endif

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .srst  (reset_i),
    .push  (push),
    .din   (din),
    .pop   (pkt_valid_o && pkt_ready_i),
    .full  (full),
    .empty (empty),
    .dout  (pkt_data_o),
    .level (fifo_level_o)
  );

  assign pkt_valid_o = !empty;

endmodule

// File: tb/tb_event_packetizer.sv
// Directed bench for event_packetizer: three instances share stimulus (default,
// TS_DIV=4, SIZE=4) so prescaling and timestamp wrap are seen side by side.
module tb_event_packetizer;
  import event_packetizer_pkg::*;

`ifdef EVENT_DROP_EN
  localparam logic RDY_RST  = 1'b1;
  localparam int   DROP_EXP = 4;
  localparam int   NEXP     = 16;
`else
  localparam logic RDY_RST  = 1'b0;
  localparam int   DROP_EXP = 0;
  localparam int   NEXP     = 20;
`endif

  logic        clk;
  logic        reset, enable, ev_valid, ev_pol, pkt_ready;
  logic [3:0]  ev_row, ev_col;

  logic        m_ev_ready, m_pkt_valid, d_ev_ready, d_pkt_valid, w_ev_ready, w_pkt_valid;
  logic [40:0] m_pkt_data, d_pkt_data;
  logic [12:0] w_pkt_data;
  logic [4:0]  m_level, d_level, w_level;
  logic [15:0] m_drop, d_drop, w_drop;

  int   errors = 0;
  int   checks = 0;
  int   nxt, nout;
  logic acc;

  int ex_ts  [7] = '{12, 14, 15, 16, 21, 22, 25};
  int ex_dts [7] = '{3, 3, 3, 4, 5, 5, 6};
  int ex_row [7] = '{1, 2, 3, 4, 7, 9, 11};
  int ex_col [7] = '{2, 3, 4, 6, 8, 10, 12};
  int ex_pol [7] = '{0, 1, 0, 1, 0, 1, 0};

  event_packetizer #(.ROW_ADD(4), .COL_ADD(4), .SIZE(32), .DEPTH(16), .TS_DIV(1)) u_m (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .ev_valid_i(ev_valid), .ev_ready_o(m_ev_ready),
    .ev_row_i(ev_row), .ev_col_i(ev_col), .ev_pol_i(ev_pol), .pkt_valid_o(m_pkt_valid),
    .pkt_ready_i(pkt_ready), .pkt_data_o(m_pkt_data), .fifo_level_o(m_level), .drop_cnt_o(m_drop));

  event_packetizer #(.ROW_ADD(4), .COL_ADD(4), .SIZE(32), .DEPTH(16), .TS_DIV(4)) u_d (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .ev_valid_i(ev_valid), .ev_ready_o(d_ev_ready),
    .ev_row_i(ev_row), .ev_col_i(ev_col), .ev_pol_i(ev_pol), .pkt_valid_o(d_pkt_valid),
    .pkt_ready_i(pkt_ready), .pkt_data_o(d_pkt_data), .fifo_level_o(d_level), .drop_cnt_o(d_drop));

  event_packetizer #(.ROW_ADD(4), .COL_ADD(4), .SIZE(4), .DEPTH(16), .TS_DIV(1)) u_w (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .ev_valid_i(ev_valid), .ev_ready_o(w_ev_ready),
    .ev_row_i(ev_row), .ev_col_i(ev_col), .ev_pol_i(ev_pol), .pkt_valid_o(w_pkt_valid),
    .pkt_ready_i(pkt_ready), .pkt_data_o(w_pkt_data), .fifo_level_o(w_level), .drop_cnt_o(w_drop));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("  ok %s = %h", tag, got);
    end
  endtask

  function automatic logic [63:0] mk(input int size, input int ts, input int row, input int col, input int pol);
    logic [63:0] t;
    t = 64'(ts) & ((64'd1 << size) - 64'd1);
    return (t << 9) | (64'(row) << 5) | (64'(col) << 1) | 64'(pol);
  endfunction

  function automatic logic [8:0] ev9(input int i);
    return {4'(i % 16), 4'(i / 16), 1'(i % 2)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic present(input int row, input int col, input int pol);
    ev_valid = 1'b1;
    ev_row   = 4'(row);
    ev_col   = 4'(col);
    ev_pol   = 1'(pol);
  endtask

  task automatic accept(input int row, input int col, input int pol);
    present(row, col, pol);
    step(1);
    ev_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; ev_valid = 1'b0; ev_row = '0; ev_col = '0; ev_pol = 1'b0; pkt_ready = 1'b0;
    step(2);
    check("rst_valid", 64'(m_pkt_valid), 64'd0);
    check("rst_level", 64'(m_level), 64'd0);
    check("rst_data",  64'(m_pkt_data), 64'd0);
    check("rst_drop",  64'(m_drop), 64'd0);
    check("rst_ready", 64'(m_ev_ready), 64'(RDY_RST));
    reset = 1'b0;

    // Cycle 10 accept: stamp 10 (TS_DIV=1), 2 (TS_DIV=4), 10 (4-bit stamp).
    step(10);
    accept(3, 5, POLARITY_ON);
    check("lat_valid", 64'(m_pkt_valid), 64'd1);
    check("lat_level", 64'(m_level), 64'd1);
    check("lat_data",  64'(m_pkt_data), mk(32, 10, 3, 5, 1));
    check("lat_ddata", 64'(d_pkt_data), mk(32, 2, 3, 5, 1));
    check("lat_wdata", 64'(w_pkt_data), mk(4, 10, 3, 5, 1));
    pkt_ready = 1'b1;
    step(1);
    pkt_ready = 1'b0;
    check("pop_valid", 64'(m_pkt_valid), 64'd0);
    check("pop_level", 64'(m_level), 64'd0);

    // Accepts at cycles 12,14,15,16,21 then enable low for 3 cycles, accepts at 25,28.
    accept(1, 2, 0);
    step(1);
    accept(2, 3, 1);
    accept(3, 4, 0);
    accept(4, 6, 1);
    step(4);
    accept(7, 8, 0);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    accept(9, 10, 1);
    step(2);
    accept(11, 12, 0);
    check("seq_level", 64'(m_level), 64'd7);
    step(2);
    pkt_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("seq_m", 64'(m_pkt_data), mk(32, ex_ts[i], ex_row[i], ex_col[i], ex_pol[i]));
      check("seq_d", 64'(d_pkt_data), mk(32, ex_dts[i], ex_row[i], ex_col[i], ex_pol[i]));
      check("seq_w", 64'(w_pkt_data), mk(4, ex_ts[i], ex_row[i], ex_col[i], ex_pol[i]));
      step(1);
    end
    pkt_ready = 1'b0;
    check("seq_empty", 64'(m_pkt_valid), 64'd0);

    // Fill with downstream stalled.
    for (int i = 0; i < 16; i++) begin
      present(i % 16, i / 16, i % 2);
      check("fill_rdy", 64'(m_ev_ready), 64'd1);
      step(1);
    end
    ev_valid = 1'b0;
    check("full_level", 64'(m_level), 64'd16);
`ifdef EVENT_DROP_EN
    for (int i = 16; i < 20; i++) begin
      present(i % 16, i / 16, i % 2);
      check("drop_rdy", 64'(m_ev_ready), 64'd1);
      step(1);
    end
    ev_valid = 1'b0;
    nxt = 20;
`else
    check("full_rdy", 64'(m_ev_ready), 64'd0);
    present(0, 1, 0);
    step(3);
    check("stall_rdy", 64'(m_ev_ready), 64'd0);
    nxt = 16;
`endif
    check("stall_level", 64'(m_level), 64'd16);
    check("drop_cnt", 64'(m_drop), 64'(DROP_EXP));

    // Drain, feeding any held-back events as space appears.
    nout = 0;
    pkt_ready = 1'b1;
    for (int c = 0; c < 80 && nout < NEXP; c++) begin
      if (m_pkt_valid) begin
        check("order", 64'(m_pkt_data[8:0]), 64'(ev9(nout)));
        nout++;
      end
      acc = ev_valid && m_ev_ready;
      step(1);
      if (acc) begin
        nxt++;
        if (nxt < 20) present(nxt % 16, nxt / 16, nxt % 2);
        else ev_valid = 1'b0;
      end
    end
    pkt_ready = 1'b0;
    ev_valid = 1'b0;
    check("drain_count", 64'(nout), 64'(NEXP));
    check("drain_level", 64'(m_level), 64'd0);

    // Reset with 5 entries queued and an accept in flight.
    for (int i = 0; i < 5; i++) accept(i, 9, 1);
    check("pre_rst_level", 64'(m_level), 64'd5);
    reset = 1'b1;
    present(15, 15, 1);
    step(1);
    check("mid_rst_ready", 64'(m_ev_ready), 64'(RDY_RST));
    reset = 1'b0;
    ev_valid = 1'b0;
    check("mid_rst_level", 64'(m_level), 64'd0);
    check("mid_rst_valid", 64'(m_pkt_valid), 64'd0);
    check("mid_rst_drop",  64'(m_drop), 64'd0);
    check("mid_rst_data",  64'(m_pkt_data), 64'd0);
    step(5);
    check("no_stale", 64'(m_pkt_valid), 64'd0);
    accept(6, 7, 1);
    check("post_rst_m", 64'(m_pkt_data), mk(32, 5, 6, 7, 1));
    check("post_rst_d", 64'(d_pkt_data), mk(32, 1, 6, 7, 1));
    check("post_rst_w", 64'(w_pkt_data), mk(4, 5, 6, 7, 1));
    check("post_rst_level", 64'(m_level), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/event_packetizer.md
# event_packetizer

Parametrised timestamping stage that sits after the top-level hierarchical arbiter. It takes one granted pixel event per handshake, in the form of a row address, a column address and a polarity bit, and stamps it with a free-running timestamp. It then buffers the packet in a synchronous FIFO and presents it to the readout link with valid/ready flow control. It generalises the fixed SIZE+ROW_ADD+COL_ADD+1 packet to independent row/column widths, configurable FIFO depth, a timestamp prescaler and an optional drop-on-full mode.

## Interface
- ROW_ADD, 4, total row-address width (sum of per-level Lvl_ADD).
- COL_ADD, 4, total column-address width; independent of ROW_ADD, so non-square arrays are allowed.
- SIZE, 32, timestamp width.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- TS_DIV, 1, number of clock cycles per timestamp tick; at least 1.
- clk_i  in  1  single clock; all logic on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  timestamp counter runs while high.
- ev_valid_i  in  1  arbiter has an event.
- ev_ready_o  out  1  block can accept the event.
- ev_row_i  in  ROW_ADD  event row address.
- ev_col_i  in  COL_ADD  event column address.
- ev_pol_i  in  1  event polarity (1 = ON).
- pkt_valid_o  out  1  FIFO head is valid.
- pkt_ready_i  in  1  downstream consumes the head.
- pkt_data_o  out  WIDTH  packet, WIDTH = SIZE+ROW_ADD+COL_ADD+1.
- fifo_level_o  out  $clog2(DEPTH+1)  current number of FIFO entries.
- drop_cnt_o  out  16  saturating count of dropped events.

## Operation
- Packet layout, MSB to LSB: {timestamp[SIZE-1:0], row, col, pol}.
- Prescaler counts 0..TS_DIV-1 while enable_i is high. The timestamp increments when the prescaler wraps. Both hold their value while enable_i is low.
- Timestamp wraps from 2^SIZE-1 to 0 without any flag.
- An accept is ev_valid_i && ev_ready_o. The stored timestamp is the counter value in the accept cycle, before any increment in that cycle.
- A pop is pkt_valid_o && pkt_ready_i. A push and a pop in the same cycle leave fifo_level_o unchanged.
- pkt_data_o shows the FIFO head. It must be stable while pkt_valid_o is high and pkt_ready_i is low.
- "Full" is decided from the registered level (level == DEPTH). A pop in the same cycle does not free space for a push.
- Reset values: all counters 0, FIFO empty, pkt_valid_o 0, fifo_level_o 0, drop_cnt_o 0, pkt_data_o 0.
- ev_ready_o depends only on registered state. Its value in reset is set by the Configuration section.
- Reset asserted mid-stream discards all FIFO contents on the next edge. Any in-flight accept in that cycle is ignored.

## Timing
- Accept at edge N into an empty FIFO: pkt_valid_o high after edge N; data visible in cycle N+1. Latency is 1 cycle.
- Back-to-back accepts: one per cycle while not full.
- With pkt_ready_i held high, throughput is one packet per cycle and the FIFO never grows beyond 1.
- fifo_level_o updates on the same edge as the push or pop.
- drop_cnt_o updates on the edge of the dropped accept and saturates at 16'hFFFF.

## Configuration
- EVENT_DROP_EN defined:
  - ev_ready_o is constantly 1, including during reset.
  - An accept while full is discarded and drop_cnt_o increments.
  - The arbiter is never stalled, which keeps pixel latency bounded.
- EVENT_DROP_EN undefined:
  - ev_ready_o = !full, and is 0 during reset.
  - No event is ever lost; the arbiter is back-pressured.
  - drop_cnt_o is tied to 0.

## Structure
- Shared package (the same arbiter package) holds:
  - the event_pkt_t packed struct built from the ROW_ADD/COL_ADD/SIZE parameters;
  - a WIDTH helper function;
  - the POLARITY_ON constant.
- One sub-module, sync_fifo (parameters WIDTH and DEPTH):
  - pointer-based storage with a registered level;
  - push/pop/full/empty ports.
- The prescaler, timestamp counter, drop counter and handshake logic live in event_packetizer.

## Test plan
- Reset, then with TS_DIV=1 and enable_i high, accept the event row=3, col=5, pol=1 in cycle 10 -> pkt_data_o = {32'd10, 4'd3, 4'd5, 1'b1}, pkt_valid_o high in cycle 11.
- TS_DIV=4, enable_i high, accept events at cycles 0, 4 and 9 -> stamps are 0, 1 and 2. Toggling enable_i low for 3 cycles shifts later stamps by exactly 3 cycles' worth of ticks.
- pkt_ready_i held low, 20 accepts attempted with DEPTH=16, EVENT_DROP_EN undefined -> ev_ready_o falls after the 16th accept and fifo_level_o = 16. After releasing pkt_ready_i, all 20 packets come out in order.
- Same stimulus with EVENT_DROP_EN defined -> 16 packets stored, drop_cnt_o = 4, ev_ready_o always 1.
- Preload the timestamp near 2^32-2 and accept events on 3 consecutive cycles -> stamps FFFFFFFE, FFFFFFFF, 00000000.
- FIFO holding 5 entries, reset_i pulsed for 1 cycle together with an accept -> fifo_level_o = 0, pkt_valid_o = 0, drop_cnt_o = 0, and no stale packet appears afterwards.
